// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: write FIFO, internal baud divider, optional parity and break generation.
// Frames are sent back-to-back on o_uart_tx while the FIFO holds data.
module uart_tx_buf #(
    parameter int unsigned P_UART_CLK        = 250_000_000,
    parameter int unsigned P_UART_BAUDRATE   = 115200,
    parameter int unsigned P_UART_DATA_WIDTH = 8,
    parameter int unsigned P_UART_STOP_WIDTH = 1,
    parameter int unsigned P_UART_CHECK      = 0,
    parameter int unsigned P_FIFO_DEPTH      = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [P_UART_DATA_WIDTH-1:0]      i_usr_tx_data,
    input  logic                              i_usr_tx_valid,
    output logic                              o_usr_tx_ready,
    input  logic                              i_tx_break,
    output logic                              o_uart_tx,
    output logic                              o_tx_busy,
    output logic                              o_tx_done,
    output logic [$clog2(P_FIFO_DEPTH):0]     o_fifo_level
);

    localparam int unsigned BAUD_DIV = P_UART_CLK / P_UART_BAUDRATE;
    localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
    localparam int unsigned ADDR_W   = $clog2(P_FIFO_DEPTH);
    localparam int unsigned LVL_W    = ADDR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       DATA_LAST = 4'(P_UART_DATA_WIDTH - 1);
    localparam logic [3:0]       STOP_LAST = 4'(P_UART_STOP_WIDTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(P_FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO
    logic [P_UART_DATA_WIDTH-1:0] mem_q [P_FIFO_DEPTH];
    logic [ADDR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]             level_q, level_d;
    logic                         ready_q;
    logic                         push, pop;
    logic                         fifo_empty;
    logic [P_UART_DATA_WIDTH-1:0] head;

    assign push       = i_usr_tx_valid & ready_q;
    assign fifo_empty = (level_q == '0);
    assign head       = mem_q[rd_ptr_q];

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_usr_tx_data;
        end
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            level_q <= level_d;
            ready_q <= (level_d < LVL_FULL);
        end
    end

    function automatic logic calc_parity(input logic [P_UART_DATA_WIDTH-1:0] d);
        case (P_UART_CHECK)
            1:       return ~^d;
            2:       return ^d;
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Transmit FSM
    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [3:0]                   bit_q, bit_d;
    logic [P_UART_DATA_WIDTH-1:0] shift_q, shift_d;
    logic                         par_q, par_d;
    logic                         tx_q, tx_d;
    logic                         brk_q, brk_d;
    logic                         bit_end;
    logic                         done;

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        brk_d   = brk_q;
        pop     = 1'b0;
        done    = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (i_tx_break) begin
                    tx_d  = 1'b0;
                    brk_d = 1'b1;
                    cnt_d = '0;
                end else if (brk_q) begin
                    // After break, hold the line high for one full bit time before any start bit.
                    tx_d = 1'b1;
                    if (bit_end) begin
                        brk_d = 1'b0;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = calc_parity(head);
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_START;
                end else begin
                    tx_d = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (P_UART_CHECK != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        done = 1'b1;
                        if (!fifo_empty && !i_tx_break) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = calc_parity(head);
                            tx_d    = 1'b0;
                            state_d = S_START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            brk_q   <= brk_d;
        end
    end

    assign o_uart_tx      = tx_q;
    assign o_tx_busy      = (state_q != S_IDLE);
    assign o_tx_done      = done;
    assign o_usr_tx_ready = ready_q;
    assign o_fifo_level   = level_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: several instances (DIV=10) cover framing, parity, widths,
// FIFO back-pressure, break and asynchronous reset.
module tb_uart_tx_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, valid, brk;
    logic [7:0] d8;
    logic [4:0] d5;
    logic [8:0] d9;

    int checks = 0;
    int errors = 0;

    logic       m_tx, m_rdy, m_busy, m_done;
    logic [2:0] m_lvl;
    logic       p_tx [4];
    logic       p_rdy [4];
    logic       p_busy [4];
    logic       p_done [4];
    logic [2:0] p_lvl [4];
    logic       s2_tx, s2_rdy, s2_busy, s2_done;
    logic [2:0] s2_lvl;
    logic       w5_tx, w5_rdy, w5_busy, w5_done;
    logic [2:0] w5_lvl;
    logic       w9_tx, w9_rdy, w9_busy, w9_done;
    logic [2:0] w9_lvl;

    uart_tx_buf #(
        .P_UART_CLK(50_000_000), .P_UART_BAUDRATE(5_000_000), .P_UART_DATA_WIDTH(8),
        .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0), .P_FIFO_DEPTH(4)
    ) u_main (
        .i_clk(clk), .i_rst(rst), .i_usr_tx_data(d8), .i_usr_tx_valid(valid),
        .o_usr_tx_ready(m_rdy), .i_tx_break(brk), .o_uart_tx(m_tx), .o_tx_busy(m_busy),
        .o_tx_done(m_done), .o_fifo_level(m_lvl)
    );

    for (genvar g = 0; g < 4; g++) begin : g_par
        uart_tx_buf #(
            .P_UART_CLK(50_000_000), .P_UART_BAUDRATE(5_000_000), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(1), .P_UART_CHECK(g + 1), .P_FIFO_DEPTH(4)
        ) u_dut (
            .i_clk(clk), .i_rst(rst), .i_usr_tx_data(d8), .i_usr_tx_valid(valid),
            .o_usr_tx_ready(p_rdy[g]), .i_tx_break(brk), .o_uart_tx(p_tx[g]), .o_tx_busy(p_busy[g]),
            .o_tx_done(p_done[g]), .o_fifo_level(p_lvl[g])
        );
    end

    uart_tx_buf #(
        .P_UART_CLK(50_000_000), .P_UART_BAUDRATE(5_000_000), .P_UART_DATA_WIDTH(8),
        .P_UART_STOP_WIDTH(2), .P_UART_CHECK(0), .P_FIFO_DEPTH(4)
    ) u_s2 (
        .i_clk(clk), .i_rst(rst), .i_usr_tx_data(d8), .i_usr_tx_valid(valid),
        .o_usr_tx_ready(s2_rdy), .i_tx_break(brk), .o_uart_tx(s2_tx), .o_tx_busy(s2_busy),
        .o_tx_done(s2_done), .o_fifo_level(s2_lvl)
    );

    uart_tx_buf #(
        .P_UART_CLK(50_000_000), .P_UART_BAUDRATE(5_000_000), .P_UART_DATA_WIDTH(5),
        .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0), .P_FIFO_DEPTH(4)
    ) u_w5 (
        .i_clk(clk), .i_rst(rst), .i_usr_tx_data(d5), .i_usr_tx_valid(valid),
        .o_usr_tx_ready(w5_rdy), .i_tx_break(brk), .o_uart_tx(w5_tx), .o_tx_busy(w5_busy),
        .o_tx_done(w5_done), .o_fifo_level(w5_lvl)
    );

    uart_tx_buf #(
        .P_UART_CLK(50_000_000), .P_UART_BAUDRATE(5_000_000), .P_UART_DATA_WIDTH(9),
        .P_UART_STOP_WIDTH(1), .P_UART_CHECK(2), .P_FIFO_DEPTH(4)
    ) u_w9 (
        .i_clk(clk), .i_rst(rst), .i_usr_tx_data(d9), .i_usr_tx_valid(valid),
        .o_usr_tx_ready(w9_rdy), .i_tx_break(brk), .o_uart_tx(w9_tx), .o_tx_busy(w9_busy),
        .o_tx_done(w9_done), .o_fifo_level(w9_lvl)
    );

    // Expected line level t clocks after the first clock of a start bit (10 clocks per bit).
    function automatic logic exp_line(input logic [8:0] d, input int nb, input int has_par,
                                      input logic pbit, input int t);
        int b;
        if (t < 0) return 1'b1;
        b = t / 10;
        if (b == 0) return 1'b0;
        if (b <= nb) return d[b-1];
        if (has_par != 0 && b == nb + 1) return pbit;
        return 1'b1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        valid = 1'b0;
        brk   = 1'b0;
        rst   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [4:0] obs;
        checks++;
        obs = {m_tx, m_rdy, m_busy, m_done, 1'b0};
        if (obs !== 5'b11000 || m_lvl !== 3'd0) begin
            errors++;
            $display("FAIL reset_main tx/rdy/busy/done=%b lvl=%0d exp 1100 lvl=0", obs[4:1], m_lvl);
        end
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (p_tx[g] !== 1'b1 || p_rdy[g] !== 1'b1 || p_busy[g] !== 1'b0 ||
                p_done[g] !== 1'b0 || p_lvl[g] !== 3'd0) begin
                errors++;
                $display("FAIL reset_par%0d tx=%b rdy=%b busy=%b done=%b lvl=%0d exp 1 1 0 0 0",
                         g, p_tx[g], p_rdy[g], p_busy[g], p_done[g], p_lvl[g]);
            end
        end
        checks++;
        obs = {s2_tx, s2_rdy, s2_busy, s2_done, 1'b0};
        if (obs !== 5'b11000 || s2_lvl !== 3'd0) begin
            errors++;
            $display("FAIL reset_s2 tx/rdy/busy/done=%b lvl=%0d exp 1100 lvl=0", obs[4:1], s2_lvl);
        end
        checks++;
        obs = {w5_tx, w5_rdy, w5_busy, w5_done, 1'b0};
        if (obs !== 5'b11000 || w5_lvl !== 3'd0) begin
            errors++;
            $display("FAIL reset_w5 tx/rdy/busy/done=%b lvl=%0d exp 1100 lvl=0", obs[4:1], w5_lvl);
        end
        checks++;
        obs = {w9_tx, w9_rdy, w9_busy, w9_done, 1'b0};
        if (obs !== 5'b11000 || w9_lvl !== 3'd0) begin
            errors++;
            $display("FAIL reset_w9 tx/rdy/busy/done=%b lvl=%0d exp 1100 lvl=0", obs[4:1], w9_lvl);
        end
    endtask

    task automatic test_frame_8n1;
        logic el;
        apply_reset();
        d8    = 8'hA5;
        valid = 1'b1;
        for (int c = 0; c <= 110; c++) begin
            el = exp_line(9'h0A5, 8, 0, 1'b0, c - 2);
            checks++;
            if (m_tx !== el) begin
                errors++;
                $display("FAIL 8n1_line c=%0d got %b exp %b", c, m_tx, el);
            end
            checks++;
            if (m_busy !== (c >= 2 && c <= 101)) begin
                errors++;
                $display("FAIL 8n1_busy c=%0d got %b exp %b", c, m_busy, (c >= 2 && c <= 101));
            end
            checks++;
            if (m_done !== (c == 101)) begin
                errors++;
                $display("FAIL 8n1_done c=%0d got %b exp %b", c, m_done, (c == 101));
            end
            tick();
            if (c == 0) valid = 1'b0;
        end
    endtask

    task automatic test_parity_stop;
        logic [3:0] pbits;
        logic       el;
        pbits = 4'b0110;  // modes odd, even, mark, space for 0x07
        apply_reset();
        d8    = 8'h07;
        valid = 1'b1;
        for (int c = 0; c <= 120; c++) begin
            for (int g = 0; g < 4; g++) begin
                el = exp_line(9'h007, 8, 1, pbits[g], c - 2);
                checks++;
                if (p_tx[g] !== el) begin
                    errors++;
                    $display("FAIL parity_mode%0d_line c=%0d got %b exp %b", g + 1, c, p_tx[g], el);
                end
                checks++;
                if (p_done[g] !== (c == 111)) begin
                    errors++;
                    $display("FAIL parity_mode%0d_done c=%0d got %b exp %b", g + 1, c, p_done[g], (c == 111));
                end
            end
            el = exp_line(9'h007, 8, 0, 1'b0, c - 2);
            checks++;
            if (s2_tx !== el || s2_busy !== (c >= 2 && c <= 111) || s2_done !== (c == 111)) begin
                errors++;
                $display("FAIL stop2 c=%0d tx/busy/done got %b%b%b exp %b%b%b", c, s2_tx, s2_busy,
                         s2_done, el, (c >= 2 && c <= 111), (c == 111));
            end
            tick();
            if (c == 0) valid = 1'b0;
        end
    endtask

    task automatic test_width;
        logic el;
        apply_reset();
        d5    = 5'h0A;
        d9    = 9'h1FF;
        valid = 1'b1;
        for (int c = 0; c <= 130; c++) begin
            el = exp_line(9'h00A, 5, 0, 1'b0, c - 2);
            checks++;
            if (w5_tx !== el || w5_busy !== (c >= 2 && c <= 71) || w5_done !== (c == 71)) begin
                errors++;
                $display("FAIL width5 c=%0d tx/busy/done got %b%b%b exp %b%b%b", c, w5_tx, w5_busy,
                         w5_done, el, (c >= 2 && c <= 71), (c == 71));
            end
            el = exp_line(9'h1FF, 9, 1, 1'b1, c - 2);
            checks++;
            if (w9_tx !== el || w9_busy !== (c >= 2 && c <= 121) || w9_done !== (c == 121)) begin
                errors++;
                $display("FAIL width9 c=%0d tx/busy/done got %b%b%b exp %b%b%b", c, w9_tx, w9_busy,
                         w9_done, el, (c >= 2 && c <= 121), (c == 121));
            end
            tick();
            if (c == 0) valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w [6];
        logic       el, eb, ed, acc;
        int         k, t, f;
        w = '{8'h11, 8'h22, 8'h3C, 8'hC3, 8'h5A, 8'hF0};
        apply_reset();
        k     = 0;
        d8    = w[0];
        valid = 1'b1;
        for (int c = 0; c <= 615; c++) begin
            t  = c - 2;
            el = 1'b1;
            eb = 1'b0;
            ed = 1'b0;
            if (t >= 0 && t < 600) begin
                f  = t / 100;
                el = exp_line({1'b0, w[f]}, 8, 0, 1'b0, t % 100);
                eb = 1'b1;
                ed = ((t % 100) == 99);
            end
            checks++;
            if (m_tx !== el || m_busy !== eb || m_done !== ed) begin
                errors++;
                $display("FAIL b2b c=%0d tx/busy/done got %b%b%b exp %b%b%b", c, m_tx, m_busy, m_done,
                         el, eb, ed);
            end
            if (c == 5) begin
                checks++;
                if (m_lvl !== 3'd4 || m_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_full lvl=%0d rdy=%b exp lvl=4 rdy=0", m_lvl, m_rdy);
                end
            end
            if (c == 101 || c == 102) begin
                checks++;
                if (m_rdy !== (c == 102)) begin
                    errors++;
                    $display("FAIL b2b_ready c=%0d got %b exp %b", c, m_rdy, (c == 102));
                end
            end
            acc = valid & m_rdy;
            tick();
            if (acc) begin
                k++;
                if (k < 6) d8 = w[k];
                else       valid = 1'b0;
            end
        end
        checks++;
        if (k != 6) begin
            errors++;
            $display("FAIL b2b_accepted got %0d exp 6", k);
        end
    endtask

    task automatic test_break;
        logic el, eb;
        apply_reset();
        d8    = 8'h3C;
        valid = 1'b1;
        for (int c = 0; c <= 270; c++) begin
            if (c < 2)         el = 1'b1;
            else if (c <= 101) el = exp_line(9'h03C, 8, 0, 1'b0, c - 2);
            else if (c == 102) el = 1'b1;
            else if (c <= 150) el = 1'b0;
            else if (c <= 160) el = 1'b1;
            else               el = exp_line(9'h055, 8, 0, 1'b0, c - 161);
            eb = (c >= 2 && c <= 101) || (c >= 161 && c <= 260);
            checks++;
            if (m_tx !== el || m_busy !== eb || m_done !== (c == 101 || c == 260)) begin
                errors++;
                $display("FAIL break c=%0d tx/busy/done got %b%b%b exp %b%b%b", c, m_tx, m_busy, m_done,
                         el, eb, (c == 101 || c == 260));
            end
            if (c == 100 || c == 150 || c == 165) begin
                checks++;
                if (m_lvl !== ((c == 165) ? 3'd0 : 3'd1)) begin
                    errors++;
                    $display("FAIL break_level c=%0d got %0d exp %0d", c, m_lvl, (c == 165) ? 0 : 1);
                end
            end
            tick();
            if (c == 0)   valid = 1'b0;
            if (c == 39)  brk = 1'b1;
            if (c == 49) begin
                d8    = 8'h55;
                valid = 1'b1;
            end
            if (c == 50)  valid = 1'b0;
            if (c == 149) brk = 1'b0;
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] w [4];
        w = '{8'h81, 8'h42, 8'h24, 8'h18};
        apply_reset();
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d8 = w[i];
            tick();
        end
        valid = 1'b0;
        for (int c = 4; c < 39; c++) tick();
        checks++;
        if (m_tx !== 1'b0 || m_lvl !== 3'd3) begin
            errors++;
            $display("FAIL midframe_pre tx=%b lvl=%0d exp tx=0 lvl=3", m_tx, m_lvl);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (m_tx !== 1'b1 || m_lvl !== 3'd0 || m_busy !== 1'b0 || m_rdy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_async tx=%b lvl=%0d busy=%b rdy=%b exp 1 0 0 1", m_tx, m_lvl,
                     m_busy, m_rdy);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 300; c++) begin
            checks++;
            if (m_tx !== 1'b1 || m_busy !== 1'b0 || m_lvl !== 3'd0) begin
                errors++;
                $display("FAIL midframe_quiet c=%0d tx=%b busy=%b lvl=%0d exp 1 0 0", c, m_tx, m_busy,
                         m_lvl);
            end
            tick();
        end
        d8    = 8'h81;
        valid = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            checks++;
            if (m_tx !== (c < 2)) begin
                errors++;
                $display("FAIL midframe_restart c=%0d got %b exp %b", c, m_tx, (c < 2));
            end
            tick();
            valid = 1'b0;
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst   = 1'b0;
        valid = 1'b0;
        brk   = 1'b0;
        d8    = '0;
        d5    = '0;
        d9    = '0;
        #2 rst = 1'b1;
        #1;
        test_reset();
        tick();
        rst = 1'b0;
        test_frame_8n1();
        test_parity_stop();
        test_width();
        test_back_to_back();
        test_break();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
